// File: rtl/dest_drain_arbiter_pkg.sv
// Shared types and constants for the destination drain arbiter.
package dest_drain_arbiter_pkg;

  localparam int unsigned BW        = 6;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned BUF_CNT_W = 2;

  // Arbiter FSM encodings
  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_ERROR  = 2'd3
  } state_e;

  localparam logic DEST_D0 = 1'b0;
  localparam logic DEST_D1 = 1'b1;

  // One output-buffer entry: source tag plus data word
  typedef struct packed {
    logic          dest;
    logic [BW-1:0] data;
  } out_word_t;

endpackage

// File: rtl/dest_drain_arbiter_out_skid2.sv
// Two-entry FIFO holding captured words until the sink accepts them.
module out_skid2
  import dest_drain_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 push,
  input  out_word_t            push_word,
  input  logic                 pop,
  output out_word_t            head,
  output logic [BUF_CNT_W-1:0] count
);

  out_word_t            mem_q [BUF_DEPTH];
  out_word_t            mem_d [BUF_DEPTH];
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic [BUF_CNT_W-1:0] count_q, count_d;
  logic                 pop_eff;

  assign pop_eff = pop && (count_q != '0);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointer and occupancy update; push and pop may coincide at any count
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_word;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_eff) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + BUF_CNT_W'(push) - BUF_CNT_W'(pop_eff);
    if (flush) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) mem_d[i] = '0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = '0;
    end
  end

  // Storage registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // The credit rule upstream must never let a push land on a full buffer
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop_eff && (count_q == BUF_CNT_W'(BUF_DEPTH))));

endmodule

// File: rtl/dest_drain_arbiter.sv
// Round-robin drain of D0/D1 into one output stream with per-source word counters.
module dest_drain_arbiter
  import dest_drain_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             D0_empty,
  input  logic             D1_empty,
  input  logic [BW-1:0]    D0_data_out,
  input  logic [BW-1:0]    D1_data_out,
  input  logic             D0_error_output,
  input  logic             D1_error_output,
  output logic             D0_rd,
  output logic             D1_rd,
  output logic [BW-1:0]    out_data,
  output logic             out_dest,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             cnt_req,
  input  logic             cnt_idx,
  output logic [CNT_W-1:0] cnt_data,
  output logic             cnt_valid,
  output logic             idle,
  output logic             error
);

  state_e           state_q, state_d;
  logic             rr_last_q, rr_last_d;
  logic             inflight_q, inflight_d;
  logic             inflight_dest_q, inflight_dest_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic [CNT_W-1:0] cnt_data_q, cnt_data_d;
  logic             cnt_valid_q, cnt_valid_d;
  logic             idle_q, idle_d;
  logic             error_q, error_d;

  out_word_t            buf_head;
  out_word_t            push_word;
  logic [BUF_CNT_W-1:0] buf_count;
  logic                 buf_pop;
  logic                 buf_flush;
  logic                 any_err;
  logic                 any_avail;
  logic                 grant;
  logic                 credit_ok;
  logic                 pop_en;
  logic [2:0]           occupancy;

  assign any_err   = D0_error_output | D1_error_output;
  assign any_avail = !D0_empty | !D1_empty;
  assign out_valid = (buf_count != '0);
  assign out_data  = buf_head.data;
  assign out_dest  = buf_head.dest;
  assign buf_pop   = out_valid & out_ready;
  assign cnt_data  = cnt_data_q;
  assign cnt_valid = cnt_valid_q;
  assign idle      = idle_q;
  assign error     = error_q;

  // Round-robin grant: alternate when both have data, else take the non-empty one
  assign grant = (!D0_empty && !D1_empty) ? ~rr_last_q : (D0_empty ? DEST_D1 : DEST_D0);

  // Credit: buffered plus in-flight words, minus a slot the sink frees this cycle
  assign occupancy = 3'(buf_count) + 3'(inflight_q);
  assign credit_ok = (occupancy - 3'(buf_pop)) < 3'(BUF_DEPTH);
  assign pop_en    = !reset && (state_q == ST_ACTIVE) && !any_err && any_avail && credit_ok;

  // Word captured from the FIFO popped on the previous cycle
  assign push_word.dest = inflight_dest_q;
  assign push_word.data = (inflight_dest_q == DEST_D1) ? D1_data_out : D0_data_out;

  // Pop issue, capture bookkeeping, counter reads and state transitions
  always_comb begin
    state_d         = state_q;
    rr_last_d       = rr_last_q;
    inflight_d      = pop_en;
    inflight_dest_d = grant;
    cnt0_d          = cnt0_q;
    cnt1_d          = cnt1_q;
    cnt_data_d      = cnt_data_q;
    cnt_valid_d     = cnt_req;
    buf_flush       = 1'b0;
    D0_rd           = pop_en && (grant == DEST_D0);
    D1_rd           = pop_en && (grant == DEST_D1);

    if (pop_en) rr_last_d = grant;

    if (inflight_q) begin
      if (inflight_dest_q == DEST_D1) cnt1_d = cnt1_q + CNT_W'(1);
      else                            cnt0_d = cnt0_q + CNT_W'(1);
    end

    // Reads return the pre-increment value
    if (cnt_req) cnt_data_d = cnt_idx ? cnt1_q : cnt0_q;

    case (state_q)
      ST_INIT: begin
        cnt0_d    = '0;
        cnt1_d    = '0;
        buf_flush = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_IDLE: begin
        if (any_err)        state_d = ST_ERROR;
        else if (any_avail) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (any_err) state_d = ST_ERROR;
        else if (!any_avail && !inflight_q && (buf_count == '0)) state_d = ST_IDLE;
      end
      default: state_d = ST_ERROR;
    endcase

    idle_d  = (state_d == ST_IDLE);
    error_d = (state_d == ST_ERROR);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_INIT;
      rr_last_q       <= 1'b1;
      inflight_q      <= 1'b0;
      inflight_dest_q <= 1'b0;
      cnt0_q          <= '0;
      cnt1_q          <= '0;
      cnt_data_q      <= '0;
      cnt_valid_q     <= 1'b0;
      idle_q          <= 1'b0;
      error_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      rr_last_q       <= rr_last_d;
      inflight_q      <= inflight_d;
      inflight_dest_q <= inflight_dest_d;
      cnt0_q          <= cnt0_d;
      cnt1_q          <= cnt1_d;
      cnt_data_q      <= cnt_data_d;
      cnt_valid_q     <= cnt_valid_d;
      idle_q          <= idle_d;
      error_q         <= error_d;
    end
  end

  out_skid2 u_out_skid2 (
    .clk       (clk),
    .reset     (reset),
    .flush     (buf_flush),
    .push      (inflight_q),
    .push_word (push_word),
    .pop       (buf_pop),
    .head      (buf_head),
    .count     (buf_count)
  );

endmodule

// File: tb/tb_dest_drain_arbiter.sv
// Scoreboard bench for dest_drain_arbiter with behavioural D0/D1 FIFO models.
module tb_dest_drain_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       D0_empty = 1'b1;
  logic       D1_empty = 1'b1;
  logic [5:0] D0_data_out = '0;
  logic [5:0] D1_data_out = '0;
  logic       D0_error_output = 1'b0;
  logic       D1_error_output = 1'b0;
  logic       D0_rd, D1_rd;
  logic [5:0] out_data;
  logic       out_dest, out_valid;
  logic       out_ready = 1'b0;
  logic       cnt_req = 1'b0;
  logic       cnt_idx = 1'b0;
  logic [4:0] cnt_data;
  logic       cnt_valid, idle, error;

  int total = 0;
  int bad   = 0;

  logic [5:0] d0_q[$];
  logic [5:0] d1_q[$];
  logic [6:0] exp_q[$];
  logic       pop_log[$];
  int         d0_pops = 0;
  int         d1_pops = 0;

  dest_drain_arbiter dut (
    .clk(clk), .reset(reset),
    .D0_empty(D0_empty), .D1_empty(D1_empty),
    .D0_data_out(D0_data_out), .D1_data_out(D1_data_out),
    .D0_error_output(D0_error_output), .D1_error_output(D1_error_output),
    .D0_rd(D0_rd), .D1_rd(D1_rd),
    .out_data(out_data), .out_dest(out_dest), .out_valid(out_valid), .out_ready(out_ready),
    .cnt_req(cnt_req), .cnt_idx(cnt_idx), .cnt_data(cnt_data), .cnt_valid(cnt_valid),
    .idle(idle), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // FIFO models: pop on the edge where rd is seen, data valid the following cycle
  always @(posedge clk) begin
    if (D0_rd || D1_rd) check("single_rd", 32'(D0_rd && D1_rd), 0);
    if (D0_rd) begin
      check("d0_underflow", 32'(d0_q.size() == 0), 0);
      if (d0_q.size() > 0) D0_data_out <= d0_q.pop_front();
      d0_pops++;
      pop_log.push_back(1'b0);
    end
    if (D1_rd) begin
      check("d1_underflow", 32'(d1_q.size() == 0), 0);
      if (d1_q.size() > 0) D1_data_out <= d1_q.pop_front();
      d1_pops++;
      pop_log.push_back(1'b1);
    end
  end

  // Empty flags follow the queue contents, settled well before the next edge
  always @(negedge clk) begin
    D0_empty = (d0_q.size() == 0);
    D1_empty = (d1_q.size() == 0);
  end

  // Scoreboard monitor: every accepted output word must match the next expected
  always @(negedge clk) begin
    logic [6:0] w;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", {25'd0, out_dest, out_data}, 32'h7f);
      end else begin
        w = exp_q.pop_front();
        check("out_word", {25'd0, out_dest, out_data}, {25'd0, w});
      end
    end
  end

  task automatic push_d0(input logic [5:0] v, input bit expect_out);
    d0_q.push_back(v);
    if (expect_out) exp_q.push_back({1'b0, v});
  endtask

  task automatic push_d1(input logic [5:0] v, input bit expect_out);
    d1_q.push_back(v);
    if (expect_out) exp_q.push_back({1'b1, v});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic cnt_read(input string nm, input logic idx, input logic [4:0] exp);
    cnt_req = 1'b1;
    cnt_idx = idx;
    tick(1);
    cnt_req = 1'b0;
    check({nm, "_valid"}, 32'(cnt_valid), 1);
    check(nm, 32'(cnt_data), 32'(exp));
    tick(1);
    check({nm, "_pulse"}, 32'(cnt_valid), 0);
  endtask

  task automatic wait_drain(input string nm, input bit want_idle);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick(1);
      if (exp_q.size() == 0 && (!want_idle || idle)) done = 1'b1;
    end
    check({nm, "_drained"}, 32'(done), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int base0, base1, base_log;
    logic exp_ord [4];
    exp_ord = '{1'b0, 1'b1, 1'b0, 1'b1};

    // Reset state
    tick(2);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_idle", 32'(idle), 0);
    check("rst_error", 32'(error), 0);
    check("rst_cnt_valid", 32'(cnt_valid), 0);
    check("rst_rd", 32'({D0_rd, D1_rd}), 0);
    reset = 1'b0;
    tick(2);
    check("init_to_idle", 32'(idle), 1);

    // 1: three D0 words, latency and back-to-back delivery
    out_ready = 1'b1;
    base0 = d0_pops;
    push_d0(6'h05, 1'b1);
    push_d0(6'h06, 1'b1);
    push_d0(6'h07, 1'b1);
    tick(2);
    check("t1_no_valid_yet", 32'(out_valid), 0);
    tick(1);
    check("t1_first_valid", 32'(out_valid), 1);
    check("t1_first_data", 32'(out_data), 32'h05);
    tick(1);
    check("t1_second_data", 32'(out_data), 32'h06);
    tick(1);
    check("t1_third_data", 32'(out_data), 32'h07);
    wait_drain("t1", 1'b1);
    check("t1_d0_pops", 32'(d0_pops - base0), 3);
    check("t1_idle", 32'(idle), 1);
    cnt_read("t1_cnt0", 1'b0, 5'd3);

    // 2: both FIFOs hold two words, strict alternation from D0
    do_reset();
    base_log = pop_log.size();
    push_d0(6'h11, 1'b0);
    push_d0(6'h12, 1'b0);
    push_d1(6'h21, 1'b0);
    push_d1(6'h22, 1'b0);
    exp_q.push_back({1'b0, 6'h11});
    exp_q.push_back({1'b1, 6'h21});
    exp_q.push_back({1'b0, 6'h12});
    exp_q.push_back({1'b1, 6'h22});
    wait_drain("t2", 1'b1);
    check("t2_pop_count", 32'(pop_log.size() - base_log), 4);
    for (int i = 0; i < 4; i++)
      if (base_log + i < pop_log.size())
        check("t2_pop_order", 32'(pop_log[base_log + i]), 32'(exp_ord[i]));

    // 3: sink stalled, credit limits pops to two, then release
    out_ready = 1'b0;
    base0 = d0_pops;
    base1 = d1_pops;
    push_d0(6'h31, 1'b1);
    push_d1(6'h01, 1'b0);
    exp_q.push_back({1'b1, 6'h01});
    push_d0(6'h32, 1'b1);
    push_d1(6'h02, 1'b1);
    tick(8);
    check("t3_stall_pops", 32'((d0_pops - base0) + (d1_pops - base1)), 2);
    check("t3_no_rd", 32'({D0_rd, D1_rd}), 0);
    check("t3_hold_valid", 32'(out_valid), 1);
    check("t3_hold_data", 32'(out_data), 32'h31);
    check("t3_hold_dest", 32'(out_dest), 0);
    out_ready = 1'b1;
    wait_drain("t3", 1'b1);
    check("t3_total_pops", 32'((d0_pops - base0) + (d1_pops - base1)), 4);

    // 4: 33 words through D1, counter wraps to 1
    do_reset();
    for (int i = 0; i < 33; i++) push_d1(6'(i + 8), 1'b1);
    wait_drain("t4", 1'b1);
    cnt_read("t4_cnt1_wrap", 1'b1, 5'd1);
    cnt_read("t4_cnt0", 1'b0, 5'd0);

    // 5: error while ACTIVE with two words held in the buffer
    do_reset();
    out_ready = 1'b0;
    base0 = d0_pops;
    for (int i = 0; i < 6; i++) push_d0(6'(6'h30 + i), 1'b0);
    tick(6);
    check("t5_pre_pops", 32'(d0_pops - base0), 2);
    D0_error_output = 1'b1;
    tick(1);
    D0_error_output = 1'b0;
    check("t5_error_set", 32'(error), 1);
    exp_q.push_back({1'b0, 6'h30});
    exp_q.push_back({1'b0, 6'h31});
    out_ready = 1'b1;
    wait_drain("t5", 1'b0);
    tick(5);
    check("t5_no_more_pops", 32'(d0_pops - base0), 2);
    check("t5_left_in_d0", 32'(d0_q.size()), 4);
    check("t5_error_sticky", 32'(error), 1);
    check("t5_not_idle", 32'(idle), 0);
    check("t5_buf_empty", 32'(out_valid), 0);
    cnt_read("t5_cnt0_in_error", 1'b0, 5'd2);

    // Reset leaves ERROR; leftover D0 words drain normally
    do_reset();
    check("t5_error_cleared", 32'(error), 0);
    for (int i = 2; i < 6; i++) exp_q.push_back({1'b0, 6'(6'h30 + i)});
    wait_drain("t5_recover", 1'b1);

    // 6: reset with a word buffered and one in flight
    out_ready = 1'b0;
    base0 = d0_pops;
    for (int i = 1; i <= 4; i++) push_d0(6'(i), 1'b0);
    tick(3);
    check("t6_pre_pops", 32'(d0_pops - base0), 2);
    check("t6_pre_valid", 32'(out_valid), 1);
    reset = 1'b1;
    tick(1);
    check("t6_rst_valid", 32'(out_valid), 0);
    check("t6_rst_idle", 32'(idle), 0);
    check("t6_rst_error", 32'(error), 0);
    check("t6_rst_rd", 32'({D0_rd, D1_rd}), 0);
    reset = 1'b0;
    cnt_req = 1'b1;
    cnt_idx = 1'b0;
    tick(1);
    cnt_req = 1'b0;
    check("t6_idle_after_init", 32'(idle), 1);
    check("t6_cnt_valid", 32'(cnt_valid), 1);
    check("t6_cnt0_cleared", 32'(cnt_data), 0);
    exp_q.push_back({1'b0, 6'h03});
    exp_q.push_back({1'b0, 6'h04});
    out_ready = 1'b1;
    wait_drain("t6", 1'b1);
    cnt_read("t6_cnt0_after", 1'b0, 5'd2);

    check("sb_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
